// File: rtl/pll_rst_pkg.sv
// pll_rst_pkg: shared types and constants for the PLL reset sequencer.
//   pll_state_e : sequencer states (2 bits)
//   RETRY_W     : width of the optional retry counter
//   RETRY_MAX   : saturation value of the optional retry counter
package pll_rst_pkg;

  typedef enum logic [1:0] {
    S_PLLRST    = 2'd0,
    S_WAIT_LOCK = 2'd1,
    S_STABLE    = 2'd2,
    S_RUN       = 2'd3
  } pll_state_e;

  localparam int              RETRY_W   = 4;
  localparam logic [RETRY_W-1:0] RETRY_MAX = 4'd15;

endpackage

// File: rtl/pll_reset_seq_bit_sync.sv
// bit_sync: STAGES-deep flop chain bringing an asynchronous level into the
// clk domain. All flops reset asynchronously to 0.
//   clk   : destination clock
//   rst_n : asynchronous active-low reset
//   d     : asynchronous input level
//   q     : synchronized level (STAGES cycles of latency)
module bit_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d};
    end
  end

  assign q = sync_q[STAGES-1];

endmodule

// File: rtl/pll_reset_seq.sv
// pll_reset_seq: reset/lock sequencer for the board PLL. Runs on the free-
// running reference clock, pulses the PLL reset, qualifies the synchronized
// lock and releases the system reset only after lock has been stable for
// LOCK_STABLE_CYCLES. Re-resets the PLL on lock timeout or lock loss.
//   clk        : reference clock (same net as PLL refclk)
//   rst_n      : asynchronous active-low reset
//   pll_locked : PLL locked, asynchronous to clk
//   pll_rst    : active-high PLL reset (registered)
//   sys_rst_n  : active-low system reset (registered)
//   ready      : high exactly while in S_RUN (registered)
//   retry_cnt  : [PLL_RETRY_STATUS_EN only] saturating timeout + lock-loss count
//   lock_lost  : [PLL_RETRY_STATUS_EN only] sticky, set on RUN -> PLLRST
//   state_dbg  : current sequencer state, for observation
// Optional feature macro: PLL_RETRY_STATUS_EN
module pll_reset_seq
  import pll_rst_pkg::*;
#(
  parameter int SYNC_STAGES         = 2,
  parameter int PLL_RST_CYCLES      = 16,
  parameter int LOCK_TIMEOUT_CYCLES = 65536,
  parameter int LOCK_STABLE_CYCLES  = 1024,
  parameter int CNT_W               = 17
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               pll_locked,
  output logic               pll_rst,
  output logic               sys_rst_n,
  output logic               ready,
`ifdef PLL_RETRY_STATUS_EN
  output logic [RETRY_W-1:0] retry_cnt,
  output logic               lock_lost,
`endif
  output pll_state_e         state_dbg
);

  localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(PLL_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);

  pll_state_e       state, state_next;
  logic [CNT_W-1:0] cnt;
  logic             lock_s;

  bit_sync #(.STAGES(SYNC_STAGES)) u_lock_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (pll_locked),
    .q     (lock_s)
  );

  // Lock events take priority over terminal counts in WAIT_LOCK and STABLE.
  always_comb begin
    state_next = state;
    case (state)
      S_PLLRST: begin
        if (cnt == RST_LAST) state_next = S_WAIT_LOCK;
      end
      S_WAIT_LOCK: begin
        if (lock_s)                   state_next = S_STABLE;
        else if (cnt == TIMEOUT_LAST) state_next = S_PLLRST;
      end
      S_STABLE: begin
        if (!lock_s)                 state_next = S_WAIT_LOCK;
        else if (cnt == STABLE_LAST) state_next = S_RUN;
      end
      S_RUN: begin
        if (!lock_s) state_next = S_PLLRST;
      end
      default: state_next = S_PLLRST;
    endcase
  end

  // Outputs are decoded from state_next so they change on the same edge as
  // the state, with no combinational path from pll_locked.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_PLLRST;
      cnt       <= '0;
      pll_rst   <= 1'b1;
      sys_rst_n <= 1'b0;
      ready     <= 1'b0;
    end else begin
      state     <= state_next;
      pll_rst   <= (state_next == S_PLLRST);
      sys_rst_n <= (state_next == S_RUN);
      ready     <= (state_next == S_RUN);
      if (state_next != state) begin
        cnt <= '0;
      end else if (cnt != '1) begin
        // Only S_RUN can dwell long enough to reach all-ones; hold there.
        cnt <= cnt + 1'b1;
      end
    end
  end

  assign state_dbg = state;

`ifdef PLL_RETRY_STATUS_EN
  logic timeout_ev, loss_ev;

  assign timeout_ev = (state == S_WAIT_LOCK) && (state_next == S_PLLRST);
  assign loss_ev    = (state == S_RUN)       && (state_next == S_PLLRST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      retry_cnt <= '0;
      lock_lost <= 1'b0;
    end else begin
      if ((timeout_ev || loss_ev) && (retry_cnt != RETRY_MAX)) begin
        retry_cnt <= retry_cnt + 1'b1;
      end
      if (loss_ev) begin
        lock_lost <= 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_pll_reset_seq.sv
// tb_pll_reset_seq: directed bench for pll_reset_seq with small timing
// parameters (sync 2, PLL reset 4, timeout 32, stable 8). Inputs change on
// the falling edge; outputs are checked on the falling edge.
module tb_pll_reset_seq;
  import pll_rst_pkg::*;

  localparam int SYNC_STAGES         = 2;
  localparam int PLL_RST_CYCLES      = 4;
  localparam int LOCK_TIMEOUT_CYCLES = 32;
  localparam int LOCK_STABLE_CYCLES  = 8;
  localparam int CNT_W               = 17;

  logic       clk;
  logic       rst_n;
  logic       pll_locked;
  logic       pll_rst;
  logic       sys_rst_n;
  logic       ready;
  pll_state_e state_dbg;
`ifdef PLL_RETRY_STATUS_EN
  logic [RETRY_W-1:0] retry_cnt;
  logic               lock_lost;
`endif

  int total;
  int bad;

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #10 clk = ~clk;

  pll_reset_seq #(
    .SYNC_STAGES         (SYNC_STAGES),
    .PLL_RST_CYCLES      (PLL_RST_CYCLES),
    .LOCK_TIMEOUT_CYCLES (LOCK_TIMEOUT_CYCLES),
    .LOCK_STABLE_CYCLES  (LOCK_STABLE_CYCLES),
    .CNT_W               (CNT_W)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .pll_locked (pll_locked),
    .pll_rst    (pll_rst),
    .sys_rst_n  (sys_rst_n),
    .ready      (ready),
`ifdef PLL_RETRY_STATUS_EN
    .retry_cnt  (retry_cnt),
    .lock_lost  (lock_lost),
`endif
    .state_dbg  (state_dbg)
  );

  // ---------------- driver tasks ----------------
  // Advance n rising edges, then park on the following falling edge.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  // ---------------- checker ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Safety net: the directed sequence is a few thousand cycles at most.
  initial begin
    #200000;
    $display("FAIL timeout observed=stuck expected=finish");
    $fatal(1, "bench time limit");
  end

  // ---------------- stimulus ----------------
  initial begin
    logic seen_release;
    total      = 0;
    bad        = 0;
    rst_n      = 1'b0;
    pll_locked = 1'b0;
    step(3);

    // Reset state
    chk("rst_pll_rst",   32'(pll_rst),   32'd1);
    chk("rst_sys_rst_n", 32'(sys_rst_n), 32'd0);
    chk("rst_ready",     32'(ready),     32'd0);
`ifdef PLL_RETRY_STATUS_EN
    chk("rst_retry_cnt", 32'(retry_cnt), 32'd0);
    chk("rst_lock_lost", 32'(lock_lost), 32'd0);
`endif

    // 1. Normal bring-up
    rst_n = 1'b1;
    step(3);
    chk("t1_pll_rst_e3", 32'(pll_rst), 32'd1);
    step(1);
    chk("t1_pll_rst_e4", 32'(pll_rst), 32'd0);
    step(6);
    pll_locked = 1'b1;                 // next rising edge is the first sample
    step(10);
    chk("t1_sys_rst_n_e10", 32'(sys_rst_n), 32'd0);
    chk("t1_ready_e10",     32'(ready),     32'd0);
    step(1);
    chk("t1_sys_rst_n_e11", 32'(sys_rst_n), 32'd1);
    chk("t1_ready_e11",     32'(ready),     32'd1);
    chk("t1_pll_rst_run",   32'(pll_rst),   32'd0);

    // 4. Lock loss in RUN
    step(3);
    pll_locked = 1'b0;
    step(2);
    chk("t4_sys_rst_n_e2", 32'(sys_rst_n), 32'd1);
    chk("t4_pll_rst_e2",   32'(pll_rst),   32'd0);
    step(1);
    chk("t4_sys_rst_n_e3", 32'(sys_rst_n), 32'd0);
    chk("t4_ready_e3",     32'(ready),     32'd0);
    chk("t4_pll_rst_e3",   32'(pll_rst),   32'd1);
`ifdef PLL_RETRY_STATUS_EN
    chk("t4_lock_lost",    32'(lock_lost), 32'd1);
    chk("t4_retry_cnt",    32'(retry_cnt), 32'd1);
`endif
    step(3);
    chk("t4_repeat_pll_rst_hi", 32'(pll_rst), 32'd1);
    step(1);
    chk("t4_repeat_pll_rst_lo", 32'(pll_rst), 32'd0);

    // 3. Glitch during qualification (now in WAIT_LOCK)
    pll_locked = 1'b1;                 // first rise sampled at E0
    step(5);                           // E0..E4 high
    pll_locked = 1'b0;                 // E5 samples low
    step(1);
    pll_locked = 1'b1;                 // second rise sampled at E6
    step(5);                           // up to E10: 11 edges after first rise
    chk("t3_no_early_release", 32'(sys_rst_n), 32'd0);
    step(5);                           // up to E15
    chk("t3_sys_rst_n_e15",    32'(sys_rst_n), 32'd0);
    step(1);                           // E16: 11 edges after second rise
    chk("t3_sys_rst_n_e16",    32'(sys_rst_n), 32'd1);
    chk("t3_ready_e16",        32'(ready),     32'd1);

    // 5. Async reset mid-STABLE
    pll_locked = 1'b0;
    step(3);
    chk("t5_pllrst_entered", 32'(pll_rst), 32'd1);
    step(4);
    chk("t5_wait_entered",   32'(pll_rst), 32'd0);
    pll_locked = 1'b1;
    step(6);                           // STABLE since edge 2
    chk("t5_pre_pll_rst",    32'(pll_rst),   32'd0);
    chk("t5_pre_sys_rst_n",  32'(sys_rst_n), 32'd0);
    #3;
    rst_n = 1'b0;
    #1;                                // no clock edge in between
    chk("t5_async_pll_rst",   32'(pll_rst),   32'd1);
    chk("t5_async_sys_rst_n", 32'(sys_rst_n), 32'd0);
    chk("t5_async_ready",     32'(ready),     32'd0);
    pll_locked = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    // 2. Lock never arrives (also re-checks the 4-cycle pulse after release)
    step(3);
    chk("t2_pll_rst_e3", 32'(pll_rst), 32'd1);
`ifdef PLL_RETRY_STATUS_EN
    chk("t2_lock_lost_cleared", 32'(lock_lost), 32'd0);
`endif
    step(1);
    chk("t2_pll_rst_e4", 32'(pll_rst), 32'd0);
    step(31);
    chk("t2_wait_cnt31", 32'(pll_rst), 32'd0);
    step(1);
    chk("t2_retry_pulse_start", 32'(pll_rst), 32'd1);
    step(3);
    chk("t2_retry_pulse_hold",  32'(pll_rst), 32'd1);
    step(1);
    chk("t2_retry_pulse_end",   32'(pll_rst), 32'd0);
    seen_release = 1'b0;
    for (int i = 0; i < 20 * 36; i++) begin
      step(1);
      if (sys_rst_n === 1'b1) seen_release = 1'b1;
    end
    chk("t2_sys_rst_n_held", 32'(seen_release), 32'd0);
    chk("t2_period_phase",   32'(pll_rst),      32'd0);
`ifdef PLL_RETRY_STATUS_EN
    chk("t2_retry_cnt_sat",  32'(retry_cnt),    32'd15);
`endif

    // 6. Simultaneous edge cases (now at WAIT_LOCK cnt=0, entered at W0)
    step(29);
    pll_locked = 1'b1;                 // sampled W30, lock_s=1 while cnt=31
    step(3);                           // W32: lock wins over timeout
    chk("t6_lock_wins_pll_rst", 32'(pll_rst), 32'd0);
    step(3);                           // W35: a retry pulse would be high here
    chk("t6_no_retry_pulse",    32'(pll_rst), 32'd0);
    step(2);                           // W37
    pll_locked = 1'b0;                 // sampled W38, lock_s=0 while cnt=7
    step(3);                           // W40: drop wins over release
    chk("t6_drop_wins_sys_rst_n", 32'(sys_rst_n), 32'd0);
    chk("t6_drop_wins_ready",     32'(ready),     32'd0);
    chk("t6_back_to_wait",        32'(pll_rst),   32'd0);
    step(31);                          // W71: timeout restarted at W40
    chk("t6_timeout_restart_lo",  32'(pll_rst),   32'd0);
    step(1);                           // W72
    chk("t6_timeout_restart_hi",  32'(pll_rst),   32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
